// File: rtl/power_mode_ctrl.sv
// Power-pellet mode controller: fright timer, ghost-eat chain scoring, eat pause and death detection.
// Optional FLASH warning phase is compiled in when POWER_FLASH_EN is defined.
module power_mode_ctrl #(
    parameter int FRIGHT_TICKS = 360,
    parameter int FLASH_TICKS  = 120,
    parameter int PAUSE_TICKS  = 30
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        tick,
    input  logic [3:0]  dot_eaten,
    input  logic [3:0]  ghost_hit,
    output logic        frightened,
    output logic        flash,
    output logic        freeze,
    output logic [3:0]  ghost_eaten,
    output logic [11:0] score_add,
    output logic        score_valid,
    output logic        pac_death,
    output logic [2:0]  dots_left,
    output logic [1:0]  dbg_state
);

    if (FLASH_TICKS >= FRIGHT_TICKS) begin : g_bad_params
        $error("FLASH_TICKS must be less than FRIGHT_TICKS");
    end

    typedef enum logic [1:0] {
        ST_NORMAL    = 2'd0,
        ST_FRIGHT    = 2'd1,
        ST_EAT_PAUSE = 2'd2
`ifdef POWER_FLASH_EN
        , ST_FLASH   = 2'd3
`endif
    } state_t;

    localparam logic [9:0] FRIGHT_T = 10'(FRIGHT_TICKS);
    localparam logic [9:0] FLASH_T  = 10'(FLASH_TICKS);
    localparam logic [4:0] PAUSE_T  = 5'(PAUSE_TICKS);

    state_t      state, state_n;
    logic [9:0]  timer, timer_n;
    logic [1:0]  chain, chain_n;
    logic [4:0]  pause, pause_n;
    logic        pending, pending_n;
    logic [2:0]  dots_n;
    logic [3:0]  eaten_n;
    logic [11:0] score_n;
    logic        sv_n, pd_n;
    logic        hit_prev;

    logic        any_dot, hit_any;
    logic [2:0]  dot_cnt;
    logic [3:0]  avail, sel_mask;
    logic [9:0]  timer_dec;
    logic [4:0]  pause_inc;

    assign any_dot   = |dot_eaten;
    assign hit_any   = |ghost_hit;
    assign dot_cnt   = 3'(dot_eaten[0]) + 3'(dot_eaten[1]) + 3'(dot_eaten[2]) + 3'(dot_eaten[3]);
    assign avail     = ghost_hit & ~ghost_eaten;
    // Isolate the lowest set bit: only one ghost is served per eat.
    assign sel_mask  = avail & (~avail + 4'd1);
    assign timer_dec = timer - 10'd1;
    assign pause_inc = pause + 5'd1;

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        chain_n   = chain;
        pause_n   = pause;
        pending_n = pending;
        eaten_n   = ghost_eaten;
        score_n   = score_add;
        sv_n      = 1'b0;
        pd_n      = 1'b0;
        dots_n    = (dots_left > dot_cnt) ? dots_left - dot_cnt : 3'd0;

        case (state)
            ST_NORMAL: begin
                if (any_dot) begin
                    state_n = ST_FRIGHT;
                    timer_n = FRIGHT_T - 10'(tick);
                    chain_n = 2'd0;
                    eaten_n = 4'd0;
                end else if (hit_any && !hit_prev) begin
                    pd_n = 1'b1;
                end
            end
            ST_EAT_PAUSE: begin
                if (any_dot) pending_n = 1'b1;
                if (tick) begin
                    pause_n = pause_inc;
                    if (pause_inc == PAUSE_T) begin
                        if (pending || any_dot) begin
                            // A dot collected while frozen restarts the power period on release.
                            state_n   = ST_FRIGHT;
                            timer_n   = FRIGHT_T;
                            chain_n   = 2'd0;
                            eaten_n   = 4'd0;
                            pending_n = 1'b0;
`ifdef POWER_FLASH_EN
                        end else if (timer <= FLASH_T) begin
                            state_n = ST_FLASH;
`endif
                        end else begin
                            state_n = ST_FRIGHT;
                        end
                    end
                end
            end
            default: begin
                if (any_dot) begin
                    state_n = ST_FRIGHT;
                    timer_n = FRIGHT_T - 10'(tick);
                    chain_n = 2'd0;
                    eaten_n = 4'd0;
                end else if (|avail) begin
                    eaten_n = ghost_eaten | sel_mask;
                    score_n = 12'd200 << chain;
                    sv_n    = 1'b1;
                    chain_n = (chain == 2'd3) ? 2'd3 : chain + 2'd1;
                    state_n = ST_EAT_PAUSE;
                    pause_n = 5'(tick);
                end else if (tick) begin
                    timer_n = timer_dec;
                    if (timer_dec == 10'd0) begin
                        state_n = ST_NORMAL;
                        eaten_n = 4'd0;
`ifdef POWER_FLASH_EN
                    end else if (timer_dec <= FLASH_T) begin
                        state_n = ST_FLASH;
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_NORMAL;
            timer       <= 10'd0;
            chain       <= 2'd0;
            pause       <= 5'd0;
            pending     <= 1'b0;
            dots_left   <= 3'd4;
            ghost_eaten <= 4'd0;
            score_add   <= 12'd0;
            score_valid <= 1'b0;
            pac_death   <= 1'b0;
            hit_prev    <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            chain       <= chain_n;
            pause       <= pause_n;
            pending     <= pending_n;
            dots_left   <= dots_n;
            ghost_eaten <= eaten_n;
            score_add   <= score_n;
            score_valid <= sv_n;
            pac_death   <= pd_n;
            hit_prev    <= hit_any;
        end
    end

    assign frightened = (state != ST_NORMAL);
    assign freeze     = (state == ST_EAT_PAUSE);
    assign dbg_state  = state;
`ifdef POWER_FLASH_EN
    assign flash = (state == ST_FLASH) || ((state == ST_EAT_PAUSE) && (timer <= FLASH_T));
`else
    assign flash = 1'b0;
`endif

endmodule

// File: tb/tb_power_mode_ctrl.sv
// Bench for power_mode_ctrl: directed scenarios with literal checks, then random stimulus
// compared every cycle against a behavioural model built on remaining-time and pause counts.
module tb_power_mode_ctrl;

    localparam int FRIGHT_TICKS = 360;
    localparam int FLASH_TICKS  = 120;
    localparam int PAUSE_TICKS  = 30;
`ifdef POWER_FLASH_EN
    localparam bit FLASH_EN = 1'b1;
`else
    localparam bit FLASH_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        tick = 1'b0;
    logic [3:0]  dot_eaten = 4'd0;
    logic [3:0]  ghost_hit = 4'd0;
    logic        frightened, flash, freeze, score_valid, pac_death;
    logic [3:0]  ghost_eaten;
    logic [11:0] score_add;
    logic [2:0]  dots_left;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    power_mode_ctrl #(
        .FRIGHT_TICKS(FRIGHT_TICKS),
        .FLASH_TICKS (FLASH_TICKS),
        .PAUSE_TICKS (PAUSE_TICKS)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .tick       (tick),
        .dot_eaten  (dot_eaten),
        .ghost_hit  (ghost_hit),
        .frightened (frightened),
        .flash      (flash),
        .freeze     (freeze),
        .ghost_eaten(ghost_eaten),
        .score_add  (score_add),
        .score_valid(score_valid),
        .pac_death  (pac_death),
        .dots_left  (dots_left),
        .dbg_state  (dbg_state)
    );

    // Clock
    always #10 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cycle, act, exp);
        end
    endtask

    // Behavioural model: power period described by remaining ticks and a pause count.
    bit   m_valid = 0;
    bit   m_power, m_in_pause, m_pending, m_prev_hit, m_sv, m_pd;
    int   m_remaining, m_pause_cnt, m_chain, m_dots, m_score;
    logic [3:0] m_eaten;

    task automatic m_start_power(input int t);
        m_power     = 1;
        m_in_pause  = 0;
        m_remaining = FRIGHT_TICKS - t;
        m_chain     = 0;
        m_eaten     = 4'd0;
    endtask

    task automatic m_reset();
        m_valid = 1; m_power = 0; m_in_pause = 0; m_pending = 0; m_prev_hit = 0;
        m_sv = 0; m_pd = 0; m_remaining = 0; m_pause_cnt = 0; m_chain = 0;
        m_dots = 4; m_score = 0; m_eaten = 4'd0;
    endtask

    task automatic m_step(input logic [3:0] d, input logic [3:0] g, input bit t);
        logic [3:0] avail;
        int idx;
        m_sv = 0;
        m_pd = 0;
        m_dots = m_dots - $countones(d);
        if (m_dots < 0) m_dots = 0;
        if (!m_power) begin
            if (d != 0) m_start_power(t);
            else if (g != 0 && !m_prev_hit) m_pd = 1;
        end else if (m_in_pause) begin
            if (d != 0) m_pending = 1;
            if (t) begin
                m_pause_cnt++;
                if (m_pause_cnt == PAUSE_TICKS) begin
                    m_in_pause = 0;
                    if (m_pending) begin
                        m_pending = 0;
                        m_start_power(0);
                    end
                end
            end
        end else begin
            avail = g & ~m_eaten;
            if (d != 0) m_start_power(t);
            else if (avail != 0) begin
                idx = 0;
                while (!avail[idx]) idx++;
                m_eaten[idx] = 1'b1;
                m_score = 200 * (1 << m_chain);
                m_sv = 1;
                if (m_chain < 3) m_chain++;
                m_in_pause = 1;
                m_pause_cnt = t;
            end else if (t) begin
                m_remaining--;
                if (m_remaining == 0) begin
                    m_power = 0;
                    m_eaten = 4'd0;
                end
            end
        end
        m_prev_hit = (g != 0);
    endtask

    // Compare process
    always @(posedge Clk) begin
        cycle++;
        if (Reset) m_reset();
        else if (m_valid) m_step(dot_eaten, ghost_hit, tick);
        #1;
        if (m_valid) begin
            chk("frightened", int'(frightened), int'(m_power));
            chk("flash", int'(flash), int'(FLASH_EN && m_power && m_remaining <= FLASH_TICKS));
            chk("freeze", int'(freeze), int'(m_power && m_in_pause));
            chk("ghost_eaten", int'(ghost_eaten), int'(m_eaten));
            chk("score_valid", int'(score_valid), int'(m_sv));
            chk("score_add", int'(score_add), m_score);
            chk("pac_death", int'(pac_death), int'(m_pd));
            chk("dots_left", int'(dots_left), m_dots);
        end
    end

    // Driver: present inputs away from the edge, then wait until after the model compare.
    task automatic drive(input logic [3:0] d, input logic [3:0] g, input bit t);
        dot_eaten = d;
        ghost_hit = g;
        tick      = t;
        @(posedge Clk);
        #2;
    endtask

    int sv_cnt, pd_cnt;
    logic [3:0] g_lvl;
    logic [3:0] d_rnd;

    initial begin
        #5;
        repeat (3) drive(4'd0, 4'd0, 1'b0);
        Reset = 1'b0;
        chk("rst_frightened", int'(frightened), 0);
        chk("rst_dots_left", int'(dots_left), 4);
        chk("rst_score_add", int'(score_add), 0);
        chk("rst_ghost_eaten", int'(ghost_eaten), 0);
        chk("rst_dbg_state", int'(dbg_state), 0);

        // Fright entry and timeout
        drive(4'b0001, 4'd0, 1'b0);
        chk("dot_frightened", int'(frightened), 1);
        chk("dot_dots_left", int'(dots_left), 3);
        repeat (239) drive(4'd0, 4'd0, 1'b1);
        chk("pre_flash", int'(flash), 0);
        drive(4'd0, 4'd0, 1'b1);
        chk("flash_at_240", int'(flash), int'(FLASH_EN));
        chk("fright_at_240", int'(frightened), 1);
        repeat (119) drive(4'd0, 4'd0, 1'b1);
        chk("fright_at_359", int'(frightened), 1);
        drive(4'd0, 4'd0, 1'b1);
        chk("fright_end", int'(frightened), 0);
        chk("flash_end", int'(flash), 0);

        // Death in NORMAL: one pulse for a held hit
        pd_cnt = 0;
        repeat (10) begin
            drive(4'd0, 4'b0001, 1'b0);
            pd_cnt += int'(pac_death);
        end
        chk("death_pulses", pd_cnt, 1);
        drive(4'd0, 4'd0, 1'b0);
        drive(4'b0010, 4'b0001, 1'b0);
        chk("dot_hit_fright", int'(frightened), 1);
        chk("dot_hit_no_death", int'(pac_death), 0);

        // Chain of four ghosts
        for (int g = 0; g < 4; g++) begin
            drive(4'd0, 4'(1 << g), 1'b0);
            chk("chain_valid", int'(score_valid), 1);
            chk("chain_score", int'(score_add), 200 << g);
            repeat (PAUSE_TICKS - 1) drive(4'd0, 4'd0, 1'b1);
            chk("chain_freeze_held", int'(freeze), 1);
            drive(4'd0, 4'd0, 1'b1);
            chk("chain_freeze_end", int'(freeze), 0);
        end
        chk("chain_all_eaten", int'(ghost_eaten), 15);

        // Two ghosts overlapping at once
        drive(4'b1000, 4'd0, 1'b0);
        sv_cnt = 0;
        drive(4'd0, 4'b0110, 1'b0);
        sv_cnt += int'(score_valid);
        chk("pair_first_score", int'(score_add), 200);
        chk("pair_first_mask", int'(ghost_eaten), 4'b0010);
        repeat (PAUSE_TICKS) begin
            drive(4'd0, 4'b0110, 1'b1);
            sv_cnt += int'(score_valid);
        end
        drive(4'd0, 4'b0110, 1'b0);
        sv_cnt += int'(score_valid);
        chk("pair_second_score", int'(score_add), 400);
        repeat (PAUSE_TICKS + 5) begin
            drive(4'd0, 4'b0110, 1'b1);
            sv_cnt += int'(score_valid);
        end
        chk("pair_score_count", sv_cnt, 2);

        // Re-trigger at timer 50 in the flash window
        repeat (305) drive(4'd0, 4'd0, 1'b1);
        chk("t50_flash", int'(flash), int'(FLASH_EN));
        drive(4'b0100, 4'd0, 1'b0);
        chk("retrig_flash", int'(flash), 0);
        chk("retrig_fright", int'(frightened), 1);
        chk("retrig_dots", int'(dots_left), 0);
        drive(4'd0, 4'b0001, 1'b0);
        chk("retrig_score", int'(score_add), 200);

        // Dot during pause, then reset mid-pause
        drive(4'b0001, 4'd0, 1'b1);
        chk("sat_dots", int'(dots_left), 0);
        repeat (3) drive(4'd0, 4'd0, 1'b1);
        Reset = 1'b1;
        sv_cnt = 0;
        repeat (2) begin
            drive(4'd0, 4'd0, 1'b1);
            sv_cnt += int'(score_valid);
        end
        Reset = 1'b0;
        drive(4'd0, 4'd0, 1'b0);
        chk("rst2_fright", int'(frightened), 0);
        chk("rst2_dots", int'(dots_left), 4);
        chk("rst2_no_score", sv_cnt + int'(score_valid), 0);

        // Random stimulus against the model
        g_lvl = 4'd0;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 7) == 0)
                g_lvl = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            d_rnd = ($urandom_range(0, 199) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            Reset = ($urandom_range(0, 4999) == 0);
            drive(d_rnd, g_lvl, 1'($urandom_range(0, 1)));
        end
        Reset = 1'b0;
        drive(4'd0, 4'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
